ps2_cmd_sequencer: RTL and testbench
====================================

Name: ps2_cmd_sequencer

Overview:
- Host-side controller for the shared bidirectional PS/2 keyboard line. Sequences command transmission (single byte, or command plus argument, e.g. 0xED + LED mask) through the host-to-keyboard transmitter.
- Waits for the keyboard ACK (0xFA) after each byte and handles resend (0xFE), retries and timeouts.
- Gates the receiver while transmitting and filters ACK/resend bytes out of the scancode stream before it reaches the Spectrum key translator.
- Sits between the ps2 receiver/transmitter pair and the translator and register file inside the keyboard wrapper.

Parameters:
- ACK_TIMEOUT, 560000, clk cycles allowed from end of a byte transmission to its ACK (20 ms at 28 MHz).
- MAX_RETRIES, 3, resends allowed per byte before failing.
- TX_TIMEOUT, 84000, clk cycles allowed for tx_busy to rise and then fall after tx_load (3 ms).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  one-cycle request strobe.
- cmd_byte  in  8  command byte.
- cmd_has_arg  in  1  send arg_byte after cmd_byte is ACKed.
- arg_byte  in  8  argument byte.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse: sequence completed and ACKed.
- error  out  1  one-cycle pulse: sequence aborted.
- err_code  out  2  cause of last abort (held until next accept): 01 ACK timeout, 10 retries exhausted, 11 transmitter timeout.
- tx_data  out  8  byte to transmitter.
- tx_load  out  1  one-cycle load strobe to transmitter.
- tx_busy  in  1  transmitter active.
- tx_error  in  1  transmitter framing/ack-bit error pulse.
- rx_enable  out  1  receiver enable.
- rx_new  in  1  receiver new-byte pulse.
- rx_code  in  8  received byte.
- key_new  out  1  filtered new-byte pulse to translator.
- key_code  out  8  filtered byte to translator.

Behaviour:
- Reset values: busy=0, done=0, error=0, err_code=00, tx_data=00, tx_load=0, rx_enable=1, key_new=0, key_code=00, state IDLE, retry count 0, timers 0.
- States: IDLE, LOAD, TX_START, TX_END, WAIT_ACK, DONE, FAIL.
- IDLE: cmd_valid=1 latches cmd_byte, arg_byte and cmd_has_arg; clears err_code and the retry count; sets busy=1 on the next cycle; sets the current byte to cmd_byte; goes to LOAD.
  - cmd_valid while busy=1 is ignored. No queueing.
- LOAD: tx_data = current byte; tx_load=1 for exactly this cycle; rx_enable=0; goes to TX_START.
- TX_START: wait for tx_busy=1, then go to TX_END. rx_enable stays 0.
- TX_END: wait for tx_busy=0, then go to WAIT_ACK. rx_enable stays 0.
- TX_START and TX_END share one counter, cleared on entering TX_START.
  - Counter reaching TX_TIMEOUT -> FAIL with code 11.
  - tx_error=1 -> treated as a resend request (see WAIT_ACK rules).
- WAIT_ACK: rx_enable=1. Counter cleared on entry and incremented every cycle.
  - rx_new with rx_code=FA:
    - if current byte is the command and the argument is pending, current byte becomes arg_byte, retry count is cleared, go to LOAD;
    - otherwise go to DONE.
  - rx_new with rx_code=FE: if retry count < MAX_RETRIES, increment it and go to LOAD (resend same byte); else go to FAIL with code 10.
  - rx_new with any other code: forwarded; state unchanged; timer keeps running.
  - Counter = ACK_TIMEOUT-1 with no rx_new -> FAIL with code 01.
  - rx_new in the same cycle as timer expiry: rx_new wins.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- FAIL: error=1 for one cycle, busy=0, err_code updated; go to IDLE.
- Filter, registered with 1-cycle latency: key_new <= rx_new unless the state is WAIT_ACK and rx_code is FA or FE; key_code <= rx_code whenever rx_new=1.
  - FA/FE received outside WAIT_ACK are forwarded unchanged.
- Timer width: $clog2(max(ACK_TIMEOUT,TX_TIMEOUT)+1). The counter saturates and never wraps.
- Reset mid-sequence: immediate return to reset values. No done/error pulse. A transmission already loaded is abandoned; the transmitter resets from the same rst.

Decomposition:
- Shared include ps2_defs.vh holds:
  - PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_CMD_LEDS=8'hED;
  - error codes;
  - state encodings.
- One natural sub-module: ps2_seq_timer (clear, enable, terminal-count compare, saturating counter). Used once, for both the TX and ACK timeouts.

Test Plan:
1. cmd ED, has_arg, arg 02; bench transmitter model and FA replies -> tx_load pulses with tx_data ED then 02; exactly one done pulse; error never asserts; busy=0 the cycle after done; no key_new for either FA.
2. Same as 1, with FE once after arg 02 -> three tx_loads (ED, 02, 02); done; retry count shown cleared between bytes.
3. cmd FF, keyboard answers FE every time, MAX_RETRIES=3 -> four tx_loads of FF; error pulse; err_code=10; no done.
4. ACK_TIMEOUT=100, no reply -> error pulse exactly 100 cycles after tx_busy falls; err_code=01. Repeat with FA arriving on cycle 99 -> done, no error.
5. Idle, rx_new code 1C -> key_new=1 one cycle later, key_code=1C. Idle, rx_new FA -> forwarded. rx_new 1C during WAIT_ACK -> forwarded, sequence continues. rx_enable=0 throughout LOAD..TX_END.
6. rst pulsed during WAIT_ACK; separately, tx_busy never rises with TX_TIMEOUT=50 -> reset gives all outputs at reset values immediately, no pulses; stuck transmitter gives error with err_code=11 50 cycles after tx_load.

Source files
------------

// File: rtl/ps2_cmd_sequencer_pkg.sv
// Shared constants and types for the PS/2 host command sequencer.
// Keyboard protocol bytes, abort causes and sequencer state encoding.
package ps2_cmd_sequencer_pkg;

  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_CMD_LEDS = 8'hED;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_ACK_TIMEOUT = 2'b01,
    ERR_RETRIES     = 2'b10,
    ERR_TX_TIMEOUT  = 2'b11
  } err_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TX_START,
    ST_TX_END,
    ST_WAIT_ACK,
    ST_DONE,
    ST_FAIL
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// Saturating cycle counter with synchronous clear and terminal-count compare.
// Shared by the transmit and ACK-wait phases of the sequencer.
module ps2_seq_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc,
  output logic         hit
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == tc);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: sends a command (and optional argument) to the
// keyboard, handles ACK/resend/timeouts and filters protocol bytes from scancodes.
module ps2_cmd_sequencer
  import ps2_cmd_sequencer_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 560000,
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned TX_TIMEOUT  = 84000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] arg_byte,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] tx_data,
  output logic       tx_load,
  input  logic       tx_busy,
  input  logic       tx_error,
  output logic       rx_enable,
  input  logic       rx_new,
  input  logic [7:0] rx_code,
  output logic       key_new,
  output logic [7:0] key_code
);

  localparam int unsigned TW = $clog2(max_u(ACK_TIMEOUT, TX_TIMEOUT) + 1);
  localparam int unsigned RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] ACK_TC    = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TX_TC     = TW'(TX_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_t        state;
  logic [7:0]    cur_byte;
  logic [7:0]    arg_q;
  logic          arg_pending;
  logic [RW-1:0] retry_cnt;

  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_hit;
  logic [TW-1:0] tmr_tc;

  logic          in_tx;
  logic          rx_ack;
  logic          rx_resend;
  logic          resend_req;

  always_comb begin
    in_tx      = (state == ST_TX_START) || (state == ST_TX_END);
    rx_ack     = rx_new && (rx_code == PS2_ACK);
    rx_resend  = rx_new && (rx_code == PS2_RESEND);
    resend_req = (in_tx && tx_error) || ((state == ST_WAIT_ACK) && rx_resend);
    // Clear on entry to TX_START (from LOAD) and on entry to WAIT_ACK.
    tmr_clr    = (state == ST_LOAD) ||
                 ((state == ST_TX_END) && !tx_error && !tx_busy);
    tmr_en     = in_tx || (state == ST_WAIT_ACK);
    tmr_tc     = (state == ST_WAIT_ACK) ? ACK_TC : TX_TC;
  end

  ps2_seq_timer #(
    .W (TW)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc),
    .hit (tmr_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur_byte    <= '0;
      arg_q       <= '0;
      arg_pending <= 1'b0;
      retry_cnt   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      tx_data     <= '0;
      tx_load     <= 1'b0;
      rx_enable   <= 1'b1;
    end else begin
      tx_load <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      // Transmitter errors and keyboard resend requests share one retry path.
      if (resend_req) begin
        if (retry_cnt < RETRY_MAX) begin
          retry_cnt <= retry_cnt + 1'b1;
          tx_data   <= cur_byte;
          tx_load   <= 1'b1;
          rx_enable <= 1'b0;
          state     <= ST_LOAD;
        end else begin
          error     <= 1'b1;
          busy      <= 1'b0;
          err_code  <= ERR_RETRIES;
          rx_enable <= 1'b1;
          state     <= ST_FAIL;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_valid) begin
              cur_byte    <= cmd_byte;
              arg_q       <= arg_byte;
              arg_pending <= cmd_has_arg;
              retry_cnt   <= '0;
              err_code    <= ERR_NONE;
              busy        <= 1'b1;
              tx_data     <= cmd_byte;
              tx_load     <= 1'b1;
              rx_enable   <= 1'b0;
              state       <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            state <= ST_TX_START;
          end
          ST_TX_START: begin
            if (tx_busy) begin
              state <= ST_TX_END;
            end else if (tmr_hit) begin
              error     <= 1'b1;
              busy      <= 1'b0;
              err_code  <= ERR_TX_TIMEOUT;
              rx_enable <= 1'b1;
              state     <= ST_FAIL;
            end
          end
          ST_TX_END: begin
            if (!tx_busy) begin
              rx_enable <= 1'b1;
              state     <= ST_WAIT_ACK;
            end else if (tmr_hit) begin
              error     <= 1'b1;
              busy      <= 1'b0;
              err_code  <= ERR_TX_TIMEOUT;
              rx_enable <= 1'b1;
              state     <= ST_FAIL;
            end
          end
          ST_WAIT_ACK: begin
            // Any received byte in the expiry cycle takes precedence over the timeout.
            if (rx_ack) begin
              if (arg_pending) begin
                arg_pending <= 1'b0;
                cur_byte    <= arg_q;
                retry_cnt   <= '0;
                tx_data     <= arg_q;
                tx_load     <= 1'b1;
                rx_enable   <= 1'b0;
                state       <= ST_LOAD;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end
            end else if (!rx_new && tmr_hit) begin
              error    <= 1'b1;
              busy     <= 1'b0;
              err_code <= ERR_ACK_TIMEOUT;
              state    <= ST_FAIL;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          ST_FAIL: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // ACK/resend bytes are swallowed only while an answer is being awaited.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_new  <= 1'b0;
      key_code <= '0;
    end else begin
      key_new <= rx_new &&
                 !((state == ST_WAIT_ACK) && ((rx_code == PS2_ACK) || (rx_code == PS2_RESEND)));
      if (rx_new) begin
        key_code <= rx_code;
      end
    end
  end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Randomized bench for ps2_cmd_sequencer with a transaction-level keyboard model.
module tb_ps2_cmd_sequencer;
  import ps2_cmd_sequencer_pkg::*;

  localparam int unsigned ACK_TO = 100;
  localparam int unsigned TX_TO  = 50;
  localparam int unsigned MAX_RT = 3;

  localparam int A_ACK    = 0;
  localparam int A_RESEND = 1;
  localparam int A_TXERR  = 2;
  localparam int A_NONE   = 3;
  localparam int A_LATE   = 4;
  localparam int A_STUCK  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_has_arg;
  logic [7:0] arg_byte;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_busy;
  logic       tx_error;
  logic       rx_enable;
  logic       rx_new;
  logic [7:0] rx_code;
  logic       key_new;
  logic [7:0] key_code;

  ps2_cmd_sequencer #(
    .ACK_TIMEOUT (ACK_TO),
    .MAX_RETRIES (MAX_RT),
    .TX_TIMEOUT  (TX_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_byte    (cmd_byte),
    .cmd_has_arg (cmd_has_arg),
    .arg_byte    (arg_byte),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_busy     (tx_busy),
    .tx_error    (tx_error),
    .rx_enable   (rx_enable),
    .rx_new      (rx_new),
    .rx_code     (rx_code),
    .key_new     (key_new),
    .key_code    (key_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-attempt keyboard/transmitter behaviour for one command sequence.
  int         plan_act[16];
  int         plan_dly[16];
  int         plan_nz[16];
  logic [7:0] plan_nzc[16];

  logic [7:0] obs_loads[$];
  logic [7:0] obs_keys[$];
  int         mon_done;
  int         mon_err;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_load) obs_loads.push_back(tx_data);
      if (key_new) obs_keys.push_back(key_code);
      if (done)    mon_done++;
      if (error)   mon_err++;
    end
  end

  logic [7:0] exp_loads[$];
  logic [7:0] exp_keys[$];
  int         exp_done;
  int         exp_err;
  logic [1:0] exp_code;
  int         exp_n;

  task automatic model(input logic [7:0] c, input logic h, input logic [7:0] a);
    logic [7:0] cur = c;
    bit pend = h;
    int rt = 0;
    bit fin = 0;
    exp_loads.delete();
    exp_keys.delete();
    exp_done = 0;
    exp_err  = 0;
    exp_code = 2'b00;
    exp_n    = 0;
    for (int i = 0; i < 16 && !fin; i++) begin
      exp_loads.push_back(cur);
      exp_n++;
      if (plan_nz[i] >= 0) exp_keys.push_back(plan_nzc[i]);
      case (plan_act[i])
        A_ACK: begin
          if (pend) begin pend = 0; cur = a; rt = 0; end
          else begin fin = 1; exp_done = 1; end
        end
        A_RESEND, A_TXERR: begin
          if (rt < int'(MAX_RT)) rt++;
          else begin fin = 1; exp_err = 1; exp_code = 2'b10; end
        end
        A_NONE: begin fin = 1; exp_err = 1; exp_code = 2'b01; end
        A_LATE: begin fin = 1; exp_err = 1; exp_code = 2'b01; exp_keys.push_back(8'hFA); end
        default: begin fin = 1; exp_err = 1; exp_code = 2'b11; end
      endcase
    end
  endtask

  task automatic set_plan(input int i, input int act, input int dly, input int nz, input logic [7:0] nzc);
    plan_act[i] = act;
    plan_dly[i] = dly;
    plan_nz[i]  = nz;
    plan_nzc[i] = nzc;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) set_plan(i, A_ACK, 3, -1, 8'h00);
  endtask

  function automatic logic [7:0] rand_noise();
    logic [7:0] v;
    do v = 8'($urandom); while (v == 8'hFA || v == 8'hFE);
    return v;
  endfunction

  task automatic random_plan();
    int r;
    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 99));
      plan_act[i] = (r < 70) ? A_ACK : (r < 84) ? A_RESEND : (r < 91) ? A_TXERR :
                    (r < 94) ? A_NONE : (r < 97) ? A_LATE : A_STUCK;
      plan_dly[i] = ($urandom_range(0, 9) == 0) ? int'(ACK_TO) - 1 : int'($urandom_range(0, 25));
      if (plan_act[i] == A_LATE) plan_dly[i] = int'(ACK_TO);
      plan_nz[i]  = -1;
      plan_nzc[i] = rand_noise();
      if ($urandom_range(0, 2) == 0) begin
        if ((plan_act[i] == A_ACK || plan_act[i] == A_RESEND) && plan_dly[i] > 0)
          plan_nz[i] = int'($urandom_range(0, plan_dly[i] - 1));
        else if (plan_act[i] == A_NONE || plan_act[i] == A_LATE)
          plan_nz[i] = int'($urandom_range(0, ACK_TO - 1));
      end
    end
  endtask

  // Entered at the negedge on which tx_load is visible.
  task automatic do_attempt(input int i);
    int  act = plan_act[i];
    int  lim;
    bit  seen = 0;
    bit  timed = (act == A_NONE) || (act == A_LATE);
    if (act == A_STUCK) begin
      for (int j = 0; j <= int'(TX_TO) + 20; j++) begin
        if (error) begin check_eq("tx_to_cycles", j, TX_TO + 1); seen = 1; break; end
        @(negedge clk);
      end
      if (!seen) check_eq("tx_to_seen", 0, 1);
      return;
    end
    @(negedge clk);
    tx_busy = 1'b1;
    check_eq("rx_en_tx", rx_enable, 0);
    if ($urandom_range(0, 4) == 0) begin
      cmd_valid = 1'b1;
      cmd_byte  = 8'($urandom);
    end
    repeat ($urandom_range(2, 6)) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    if (act == A_TXERR) begin
      tx_error = 1'b1;
      tx_busy  = 1'b0;
      @(negedge clk);
      tx_error = 1'b0;
      return;
    end
    tx_busy = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (rx_enable) begin seen = 1; break; end
    end
    if (!seen) begin check_eq("rx_en_rise", 0, 1); return; end
    seen = 0;
    lim = timed ? int'(ACK_TO) + 20 : plan_dly[i];
    for (int j = 0; j <= lim; j++) begin
      rx_new = 1'b0;
      if (plan_nz[i] == j) begin rx_new = 1'b1; rx_code = plan_nzc[i]; end
      if (act != A_NONE && j == plan_dly[i]) begin
        rx_new  = 1'b1;
        rx_code = (act == A_RESEND) ? PS2_RESEND : PS2_ACK;
      end
      if (timed && error) begin check_eq("ack_to_cycles", j, ACK_TO); seen = 1; end
      @(negedge clk);
      if (seen) break;
    end
    rx_new = 1'b0;
    if (timed && !seen) check_eq("ack_to_seen", 0, 1);
  endtask

  task automatic run_cmd(input logic [7:0] c, input logic h, input logic [7:0] a);
    bit got;
    model(c, h, a);
    @(negedge clk);
    obs_loads.delete();
    obs_keys.delete();
    mon_done    = 0;
    mon_err     = 0;
    cmd_valid   = 1'b1;
    cmd_byte    = c;
    cmd_has_arg = h;
    arg_byte    = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("busy_accept", busy, 1);
    for (int i = 0; i < exp_n; i++) begin
      got = 0;
      for (int k = 0; k < 200; k++) begin
        if (tx_load) begin got = 1; break; end
        @(negedge clk);
      end
      if (!got) begin check_eq("load_seen", 0, 1); break; end
      check_eq("rx_en_load", rx_enable, 0);
      do_attempt(i);
    end
    got = 0;
    for (int k = 0; k < 400; k++) begin
      if (mon_done + mon_err != 0) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) check_eq("end_seen", 0, 1);
    repeat (3) @(negedge clk);
    check_eq("n_loads", obs_loads.size(), exp_loads.size());
    for (int i = 0; i < exp_loads.size() && i < obs_loads.size(); i++)
      check_eq("load_byte", obs_loads[i], exp_loads[i]);
    check_eq("done_cnt", mon_done, exp_done);
    check_eq("err_cnt", mon_err, exp_err);
    check_eq("err_code", err_code, exp_code);
    check_eq("busy_end", busy, 0);
    check_eq("n_keys", obs_keys.size(), exp_keys.size());
    for (int i = 0; i < exp_keys.size() && i < obs_keys.size(); i++)
      check_eq("key_byte", obs_keys[i], exp_keys[i]);
  endtask

  task automatic idle_forward(input logic [7:0] code);
    @(negedge clk);
    rx_new  = 1'b1;
    rx_code = code;
    @(negedge clk);
    rx_new = 1'b0;
    check_eq("idle_key_new", key_new, 1);
    check_eq("idle_key_code", key_code, code);
    @(negedge clk);
    check_eq("idle_key_new_off", key_new, 0);
  endtask

  task automatic reset_mid_wait();
    bit got = 0;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_byte    = PS2_CMD_LEDS;
    cmd_has_arg = 1'b1;
    arg_byte    = 8'h05;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    tx_busy = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (rx_enable) begin got = 1; break; end
    end
    if (!got) check_eq("rst_rx_en_rise", 0, 1);
    rx_new  = 1'b1;
    rx_code = 8'h1C;
    @(negedge clk);
    rx_new = 1'b0;
    repeat (3) @(negedge clk);
    mon_done = 0;
    mon_err  = 0;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_outs",
             {busy, done, error, err_code, tx_data, tx_load, rx_enable, key_new, key_code},
             {1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rst_no_done", mon_done, 0);
    check_eq("rst_no_err", mon_err, 0);
    check_eq("rst_busy", busy, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_byte    = 8'h00;
    cmd_has_arg = 1'b0;
    arg_byte    = 8'h00;
    tx_busy     = 1'b0;
    tx_error    = 1'b0;
    rx_new      = 1'b0;
    rx_code     = 8'h00;
    mon_done    = 0;
    mon_err     = 0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs",
             {busy, done, error, err_code, tx_data, tx_load, rx_enable, key_new, key_code},
             {1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00});
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // LED command with argument, both ACKed
    clear_plan();
    run_cmd(PS2_CMD_LEDS, 1'b1, 8'h02);
    // one resend on the argument
    clear_plan();
    set_plan(1, A_RESEND, 4, -1, 8'h00);
    run_cmd(PS2_CMD_LEDS, 1'b1, 8'h02);
    // full retry budget on each byte: retry count restarts for the argument
    clear_plan();
    for (int i = 0; i < 3; i++) begin
      set_plan(i, A_RESEND, 2, -1, 8'h00);
      set_plan(i + 4, A_RESEND, 2, -1, 8'h00);
    end
    run_cmd(PS2_CMD_LEDS, 1'b1, 8'h07);
    // resend forever: retries exhausted
    clear_plan();
    for (int i = 0; i < 5; i++) set_plan(i, A_RESEND, 1, -1, 8'h00);
    run_cmd(8'hFF, 1'b0, 8'h00);
    // no reply; reply on the last accepted cycle; reply one cycle too late
    clear_plan();
    set_plan(0, A_NONE, 0, -1, 8'h00);
    run_cmd(8'hF4, 1'b0, 8'h00);
    clear_plan();
    set_plan(0, A_ACK, int'(ACK_TO) - 1, -1, 8'h00);
    run_cmd(8'hF4, 1'b0, 8'h00);
    clear_plan();
    set_plan(0, A_LATE, int'(ACK_TO), -1, 8'h00);
    run_cmd(8'hF4, 1'b0, 8'h00);
    // scancode arriving while waiting for ACK is forwarded
    clear_plan();
    set_plan(0, A_ACK, 20, 5, 8'h1C);
    run_cmd(8'hF2, 1'b0, 8'h00);
    // transmitter error as resend, then stuck transmitter
    clear_plan();
    set_plan(0, A_TXERR, 0, -1, 8'h00);
    run_cmd(PS2_CMD_LEDS, 1'b1, 8'h04);
    clear_plan();
    set_plan(0, A_STUCK, 0, -1, 8'h00);
    run_cmd(8'hEE, 1'b0, 8'h00);

    // idle forwarding, including protocol bytes
    idle_forward(8'h1C);
    idle_forward(PS2_ACK);
    idle_forward(PS2_RESEND);
    for (int i = 0; i < 4; i++) idle_forward(8'($urandom));

    reset_mid_wait();

    for (int n = 0; n < 120; n++) begin
      random_plan();
      run_cmd(8'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
